// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and the
// registered memory request bundle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } mem_arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_st;

  // Instruction fetches always read the full word.
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Wait counter for one memory access plus the sticky timeout flag.
// The counter restarts whenever the arbiter enters a new busy state and
// counts cycles in which the memory has not answered.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYC = 256,
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Abort in the cycle the counter sits at its last value with ready still low.
  assign timeout_o = busy_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign err_o     = err_q;

  // Next-state for counter and sticky error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout_o;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !ready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port variable-latency memory between the fetch
// (instruction) port and the memory-stage (data) port. Data has priority.
// Handshake: a port request stays high until its one-cycle *_valid_o pulse;
// mem_req_o is held with stable mem_* fields until mem_ready_i is seen high.
// Fetches killed by a taken branch are drained and discarded silently.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           if_req_i,
  input  logic [31:0]    if_addr_i,
  input  logic           if_kill_i,
  output logic [31:0]    if_rdata_o,
  output logic           if_valid_o,
  output logic           if_stall_o,
  input  logic           d_req_i,
  input  logic           d_we_i,
  input  logic [31:0]    d_addr_i,
  input  logic [31:0]    d_wdata_i,
  input  logic [3:0]     d_be_i,
  output logic [31:0]    d_rdata_o,
  output logic           d_valid_o,
  output logic           d_stall_o,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [31:0]    mem_addr_o,
  output logic [31:0]    mem_wdata_o,
  output logic [3:0]     mem_be_o,
  input  logic           mem_ready_i,
  input  logic [31:0]    mem_rdata_i,
  output logic           err_o,
  output mem_arb_state_e state_o
);

  mem_arb_state_e state_q, state_d;
  mem_req_st      req_q, req_d;
  logic [31:0]    if_rdata_q, if_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;
  logic           if_valid_q, if_valid_d;
  logic           d_valid_q, d_valid_d;
  logic           busy, start, timeout;

  assign busy  = (state_q != ST_IDLE);
  // Counter restarts on every entry into a busy state, including FETCH->DRAIN.
  assign start = (state_d != ST_IDLE) && (state_d != state_q);

  mem_arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start),
    .busy_i    (busy),
    .ready_i   (mem_ready_i),
    .timeout_o (timeout),
    .err_o     (err_o)
  );

  // Next-state, grant and completion logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The ~valid guards stop a completing request being re-granted in its pulse cycle.
        if (d_req_i && !d_valid_q) begin
          req_d   = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_be_i};
          state_d = ST_DATA;
        end else if (if_req_i && !if_valid_q && !if_kill_i) begin
          req_d   = '{we: 1'b0, addr: if_addr_i, wdata: 32'h0, be: BE_WORD};
          state_d = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (mem_ready_i) begin
          d_rdata_d = mem_rdata_i;
          d_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ready_i) begin
          if (!if_kill_i) begin
            if_rdata_d = mem_rdata_i;
            if_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end else if (if_kill_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Memory cannot cancel an access, so wait it out and drop the data.
        if (mem_ready_i || timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_be_o    = req_q.be;
  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign if_stall_o  = if_req_i & ~if_valid_q;
  assign d_stall_o   = d_req_i & ~d_valid_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           if_req_i, if_kill_i, d_req_i, d_we_i, mem_ready_i;
  logic [31:0]    if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]     d_be_i;
  logic [31:0]    if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic           if_valid_o, if_stall_o, d_valid_o, d_stall_o;
  logic           mem_req_o, mem_we_o, err_o;
  logic [3:0]     mem_be_o;
  mem_arb_state_e state_o;

  int total = 0;
  int bad   = 0;
  int stall_total = 0;
  int s0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];

  mem_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o), .state_o(state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: pops expected response on every completion pulse.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (if_stall_o) stall_total++;
      if (if_valid_o) begin
        if (exp_if_q.size() == 0) chk("if_unexpected_pulse", 32'h1, 32'h0);
        else chk("if_rdata", if_rdata_o, exp_if_q.pop_front());
      end
      if (d_valid_o) begin
        if (exp_d_q.size() == 0) chk("d_unexpected_pulse", 32'h1, 32'h0);
        else chk("d_rdata", d_rdata_o, exp_d_q.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b1; if_req_i = 0; if_kill_i = 0; d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; d_be_i = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    rst_i = 1'b0;

    // 1: fetch only, ready on the third FETCH cycle
    tick(); if_req_i = 1; if_addr_i = 32'h1000; exp_if_q.push_back(32'h00500093); s0 = stall_total;
    tick(); chk("t1_state", 32'(state_o), 32'(ST_FETCH));
    chk("t1_mem_req", 32'(mem_req_o), 32'h1); chk("t1_addr", mem_addr_o, 32'h1000);
    chk("t1_we", 32'(mem_we_o), 32'h0); chk("t1_be", 32'(mem_be_o), 32'hF);
    tick();
    tick(); mem_ready_i = 1; mem_rdata_i = 32'h00500093;
    tick(); mem_ready_i = 0; if_req_i = 0;
    chk("t1_pulse", 32'(if_valid_o), 32'h1);
    tick(); chk("t1_stall_cycles", 32'(stall_total - s0), 32'd4);
    chk("t1_pulse_width", 32'(if_valid_o), 32'h0); chk("t1_idle_req", 32'(mem_req_o), 32'h0);

    // 2: simultaneous data load and fetch, data first
    tick(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; d_be_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h2000;
    exp_d_q.push_back(32'hAAAA0001); exp_if_q.push_back(32'h00000013);
    tick(); chk("t2_state", 32'(state_o), 32'(ST_DATA)); chk("t2_addr", mem_addr_o, 32'h100);
    mem_ready_i = 1; mem_rdata_i = 32'hAAAA0001;
    tick(); mem_ready_i = 0; d_req_i = 0;
    chk("t2_dpulse", 32'(d_valid_o), 32'h1); chk("t2_req_gap", 32'(mem_req_o), 32'h0);
    tick(); chk("t2_fetch_state", 32'(state_o), 32'(ST_FETCH)); chk("t2_faddr", mem_addr_o, 32'h2000);
    mem_ready_i = 1; mem_rdata_i = 32'h00000013;
    tick(); mem_ready_i = 0; if_req_i = 0;
    tick();

    // 3: store, fields stable while waiting
    tick(); d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hDEADBEEF; d_be_i = 4'b0011;
    exp_d_q.push_back(32'h0);
    tick(); d_addr_i = 32'h999; d_wdata_i = 32'h0; d_be_i = 4'hF; d_we_i = 0;
    chk("t3_dstall", 32'(d_stall_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_we", 32'(mem_we_o), 32'h1); chk("t3_be", 32'(mem_be_o), 32'h3);
      chk("t3_addr", mem_addr_o, 32'h200); chk("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
      if (i == 2) begin mem_ready_i = 1; mem_rdata_i = 32'h0; end
      else tick();
    end
    tick(); mem_ready_i = 0; chk("t3_dstall_done", 32'(d_stall_o), 32'h0); d_req_i = 0;
    tick();

    // 4: kill during FETCH, drain, refetch new PC
    tick(); if_req_i = 1; if_addr_i = 32'h3000;
    tick(); chk("t4_fetch", 32'(state_o), 32'(ST_FETCH)); if_kill_i = 1; if_addr_i = 32'h4000;
    tick(); chk("t4_drain", 32'(state_o), 32'(ST_DRAIN)); chk("t4_drain_req", 32'(mem_req_o), 32'h1);
    if_kill_i = 0;
    tick(); mem_ready_i = 1; mem_rdata_i = 32'h00000BAD;
    tick(); mem_ready_i = 0; chk("t4_no_pulse", 32'(if_valid_o), 32'h0);
    chk("t4_idle", 32'(state_o), 32'(ST_IDLE)); exp_if_q.push_back(32'h00A00113);
    tick(); chk("t4_new_pc", mem_addr_o, 32'h4000); mem_ready_i = 1; mem_rdata_i = 32'h00A00113;
    tick(); mem_ready_i = 0; if_req_i = 0;
    tick();

    // 5: kill and ready in the same FETCH cycle
    tick(); if_req_i = 1; if_addr_i = 32'h5000;
    tick(); chk("t5_fetch", 32'(state_o), 32'(ST_FETCH));
    if_kill_i = 1; mem_ready_i = 1; mem_rdata_i = 32'h0000DEAD; if_addr_i = 32'h6000;
    tick(); chk("t5_idle", 32'(state_o), 32'(ST_IDLE)); chk("t5_no_pulse", 32'(if_valid_o), 32'h0);
    if_kill_i = 0; mem_ready_i = 0; if_req_i = 0;
    tick();

    // 6: timeout, re-grant, then reset mid-access
    tick(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_be_i = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      tick(); chk("t6_waiting", 32'({mem_req_o, err_o}), 32'h2);
    end
    tick(); chk("t6_err", 32'(err_o), 32'h1); chk("t6_req_drop", 32'(mem_req_o), 32'h0);
    tick(); chk("t6_regrant", 32'(mem_req_o), 32'h1); chk("t6_err_sticky", 32'(err_o), 32'h1);
    rst_i = 1; d_req_i = 0;
    tick(); rst_i = 0;
    chk("t6_rst_req", 32'(mem_req_o), 32'h0); chk("t6_rst_err", 32'(err_o), 32'h0);
    chk("t6_rst_addr", mem_addr_o, 32'h0); chk("t6_rst_state", 32'(state_o), 32'(ST_IDLE));
    tick(); tick();

    chk("if_queue_empty", 32'(exp_if_q.size()), 32'h0);
    chk("d_queue_empty", 32'(exp_d_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
